cdc_handshake_tx: RTL and testbench

//   Source-domain end of a 4-phase req/ack CDC handshake. Accepts words on a valid/ready

---
 rtl/cdc_pkg.sv | 8 +
 rtl/cdc_handshake_tx_if.sv | 25 ++
 rtl/cdc_level_sync.sv | 28 ++
 rtl/cdc_handshake_tx.sv | 114 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the CDC handshake blocks (tx end now, rx end later).
package cdc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DROP} cdc_tx_state_t;

    localparam int unsigned CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Signal bundle for cdc_handshake_tx: upstream valid/ready port plus the req/ack CDC pair.
interface cdc_handshake_tx_if #(
    parameter int unsigned DATA_W = 8
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ack_async;
    logic              err_timeout;

    // master: the handshake transmitter; slave: upstream source plus far end
    modport master (
        input  s_valid, s_data, tx_ack_async,
        output s_ready, tx_req, tx_data, err_timeout
    );

    modport slave (
        output s_valid, s_data, tx_ack_async,
        input  s_ready, tx_req, tx_data, err_timeout
    );

endinterface

// File: rtl/cdc_level_sync.sv
// Multi-flop level synchronizer with asynchronous active-high reset.
module cdc_level_sync
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Fewer than two stages gives no metastability protection, so clamp up
    localparam int unsigned N = (STAGES < CDC_MIN_SYNC_STAGES) ? CDC_MIN_SYNC_STAGES : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a 4-phase req/ack CDC handshake; tx_data is held stable while req is high.
// Optional sticky per-phase timeout flag enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    cdc_handshake_tx_if.master  bus
);

    cdc_tx_state_t     state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_s;
    logic              ready;

    cdc_level_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.tx_ack_async),
        .q   (ack_s)
    );

    // A stale high ack in IDLE blocks acceptance until it falls
    assign ready = (state_q == IDLE) && !ack_s;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.s_valid && ready) begin
                    data_d  = bus.s_data;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    assign bus.s_ready = ready;
    assign bus.tx_req  = req_q;
    assign bus.tx_data = data_q;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter saturates at the limit; the FSM keeps waiting regardless
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE && cnt_q != CNT_W'(TIMEOUT_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q != IDLE && cnt_d == CNT_W'(TIMEOUT_CYC)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a 3-cycle echo far-end model.
module tb_cdc_handshake_tx;
    import cdc_pkg::*;

`ifdef CDC_TX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cdc_handshake_tx_if #(.DATA_W(8)) bus ();

    cdc_handshake_tx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Far end: ack follows req three clock edges later when enabled
    logic       far_en = 1'b0;
    logic [1:0] dly;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= '0;
            if (far_en) bus.tx_ack_async <= 1'b0;
        end else begin
            dly <= {dly[0], bus.tx_req};
            if (far_en) bus.tx_ack_async <= dly[1];
        end
    end

    // Record the word carried by each req rising edge
    logic       prev_req = 1'b0;
    int         npulse = 0;
    logic [7:0] caught [0:15];
    always @(posedge clk) begin
        if (bus.tx_req && !prev_req) begin
            caught[npulse % 16] = bus.tx_data;
            npulse++;
        end
        prev_req = bus.tx_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    logic ok;
    int   base;

    initial begin
        rst              = 1'b1;
        bus.s_valid      = 1'b0;
        bus.s_data       = 8'h00;
        bus.tx_ack_async = 1'b0;
        #1;
        // 1: reset state
        chk("rst_req", 32'(bus.tx_req), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'h00);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        // 2: single word A5 through the echo far end
        far_en      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        tick();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'hFF;
        chk("a5_req", 32'(bus.tx_req), 32'd1);
        chk("a5_data", 32'(bus.tx_data), 32'hA5);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("a5_hold_%0d", k), 32'(bus.tx_data), 32'hA5);
            chk($sformatf("a5_busy_%0d", k), 32'(bus.s_ready), 32'd0);
            chk($sformatf("a5_req_%0d", k), 32'(bus.tx_req), 32'(k < 6));
        end
        tick();
        chk("a5_done_ready", 32'(bus.s_ready), 32'd1);
        chk("a5_done_state", 32'(dut.state_q), 32'(IDLE));

        // 3: back-to-back words with s_valid held
        base = npulse;
        for (int w = 1; w <= 3; w++) begin
            bus.s_data  = 8'(w);
            bus.s_valid = 1'b1;
            wait_ready(60, ok);
            chk($sformatf("b2b_wait_%0d", w), 32'(ok), 32'd1);
            tick();
        end
        bus.s_valid = 1'b0;
        wait_ready(60, ok);
        chk("b2b_idle", 32'(ok), 32'd1);
        tick();
        chk("b2b_count", 32'(npulse - base), 32'd3);
        chk("b2b_w0", 32'(caught[base % 16]), 32'h01);
        chk("b2b_w1", 32'(caught[(base + 1) % 16]), 32'h02);
        chk("b2b_w2", 32'(caught[(base + 2) % 16]), 32'h03);

        // 4: ack held high through reset release
        far_en           = 1'b0;
        bus.tx_ack_async = 1'b1;
        rst              = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("stale_ready", 32'(bus.s_ready), 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        tick();
        tick();
        tick();
        chk("stale_noreq", 32'(bus.tx_req), 32'd0);
        chk("stale_state", 32'(dut.state_q), 32'(IDLE));
        bus.s_valid      = 1'b0;
        bus.tx_ack_async = 1'b0;
        tick();
        chk("stale_fall1", 32'(bus.s_ready), 32'd0);
        tick();
        chk("stale_fall2", 32'(bus.s_ready), 32'd1);

        // 5: reset while in REQ, then a normal word
        far_en      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        tick();
        bus.s_valid = 1'b0;
        chk("mid_req", 32'(bus.tx_req), 32'd1);
        tick();
        chk("mid_state", 32'(dut.state_q), 32'(REQ));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.tx_req), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h3C;
        tick();
        bus.s_valid = 1'b0;
        chk("3c_req", 32'(bus.tx_req), 32'd1);
        chk("3c_data", 32'(bus.tx_data), 32'h3C);
        tick();
        wait_ready(60, ok);
        chk("3c_done", 32'(ok), 32'd1);
        chk("3c_state", 32'(dut.state_q), 32'(IDLE));
        chk("3c_keep", 32'(bus.tx_data), 32'h3C);

        // 6: silent far end, timeout flag
        far_en           = 1'b0;
        bus.tx_ack_async = 1'b0;
        bus.s_valid      = 1'b1;
        bus.s_data       = 8'h5A;
        tick();
        bus.s_valid = 1'b0;
        repeat (15) tick();
        chk("to_early", 32'(bus.err_timeout), 32'd0);
        tick();
        chk("to_hit", 32'(bus.err_timeout), 32'(TO_EN));
        repeat (5) tick();
        chk("to_sticky", 32'(bus.err_timeout), 32'(TO_EN));
        chk("to_wait", 32'(dut.state_q), 32'(REQ));
        bus.tx_ack_async = 1'b1;
        tick();
        tick();
        tick();
        chk("to_drop_req", 32'(bus.tx_req), 32'd0);
        chk("to_drop_state", 32'(dut.state_q), 32'(DROP));
        bus.tx_ack_async = 1'b0;
        wait_ready(60, ok);
        chk("to_done", 32'(ok), 32'd1);
        chk("to_err_after", 32'(bus.err_timeout), 32'(TO_EN));
        chk("to_data", 32'(bus.tx_data), 32'h5A);
        rst = 1'b1;
        #1;
        chk("to_rst_clear", 32'(bus.err_timeout), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
